reg32_serializer: RTL and testbench
===================================

Name: reg32_serializer

Overview:
Transmit-side companion to the parallel load register. Captures a WIDTH-bit word on a load request and shifts it out bit-serially, MSB first, each bit held for DIV clocks. Provides a per-bit sample strobe and a completion pulse, so a downstream serial-in register can reassemble the word. Sits between a datapath register and a serial link or peripheral shifter.

Parameters:
WIDTH, 32, word length in bits; legal range is 2 or more.
DIV, 4, clocks per serial bit; legal range is 1 or more. DIV=1 gives one bit per clock.

Ports:
clk      input   1      system clock, rising-edge active
clear    input   1      asynchronous, active-high reset
load     input   1      request to capture D; honoured only while ready=1
D        input   WIDTH  parallel word to transmit
ready    output  1      high in IDLE; a load is accepted on this cycle
sdata    output  1      current serial bit; 0 when not shifting
svalid   output  1      high while a bit is being presented
bit_tick output  1      one-cycle pulse on the last clock of each bit; receiver samples sdata here
done     output  1      one-cycle pulse after the final bit

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-high (clear).
- clear=1 forces, immediately and without a clock edge:
  - state=IDLE, shift register=0, div_cnt=0, bit_cnt=0
  - ready=1, sdata=0, svalid=0, bit_tick=0, done=0
- clear asserted mid-transfer aborts the transfer. No done is issued, and nothing resumes after clear drops.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - ready=1.
  - On a rising edge with load=1: shreg<=D, div_cnt<=0, bit_cnt<=0, state<=SHIFT.
  - load=0 keeps the block in IDLE.
- SHIFT:
  - ready=0, svalid=1, sdata=shreg[WIDTH-1].
  - div_cnt counts 0..DIV-1. bit_tick = (div_cnt==DIV-1), decoded from registered state.
  - On an edge with bit_tick=1: shreg shifts left with 0 fill, div_cnt<=0, bit_cnt<=bit_cnt+1.
  - When bit_cnt==WIDTH-1 and bit_tick=1: state<=DONE.
- DONE:
  - done=1 for exactly one cycle, with svalid=0 and sdata=0.
  - Next edge goes to IDLE unconditionally.
- Timing from the accepting edge E:
  - svalid is high for exactly WIDTH*DIV cycles, starting the cycle after E.
  - done is high in the single cycle after that.
  - ready returns the cycle after done.
  - Minimum load-to-load spacing is WIDTH*DIV+2 clocks.
- load while ready=0 (SHIFT or DONE) is ignored. It is neither queued nor allowed to disturb shreg.
- D is sampled only on the accepting edge. Later changes to D do not affect the word in flight.
- Counter widths:
  - bit_cnt is clog2(WIDTH) bits.
  - div_cnt is max(1, clog2(DIV)) bits.
  - Neither counter is allowed to wrap past its terminal value.
- Output paths:
  - All outputs are decoded from registers only. There is no combinational path from load or D to any output.
  - This holds for ready too: it is a function of state only.

Decomposition:
- Shared package:
  - state encoding constants: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10
  - clog2 helper function
- One natural sub-module, bit_tick_gen: the DIV-cycle divider.
  - Inputs: clk, clear, run.
  - Output: tick.
  - Internal count resets to 0 while run=0.
  - It is reusable by the matching deserializer.
- Shift register and bit counter stay in reg32_serializer.

Test Plan:
- Reset and idle hold. Assert clear mid-cycle with load=1 and D=0xFFFFFFFF → all outputs immediately 0 except ready=1. No transfer starts while clear=1.
- Basic frame (WIDTH=32, DIV=4). Load 0xA5A50F0F → svalid high 128 cycles. The 32 bit_tick pulses are 4 clocks apart. sdata sampled at bit_tick spells 0xA5A50F0F MSB first. done pulses once in cycle 129 after the load edge, and ready=1 in cycle 130.
- Load ignored while busy. Issue a second load with D=0x12345678 at bit 10 and again during DONE → output stream is still 0xA5A50F0F. ready stays 0 and no extra frame follows.
- DIV=1 (WIDTH=8). Load 0x81 → svalid for 8 consecutive cycles with sdata=1,0,0,0,0,0,0,1 and bit_tick high every cycle. done appears on cycle 9.
- Abort. Assert clear during bit 20 of 0xDEADBEEF → sdata, svalid and bit_tick drop at once with no done. A subsequent load of 0x0000FFFF transmits cleanly: 16 zeros, then 16 ones.
- Back-to-back. Reload 0x00000001 on the first ready cycle after done → frame starts with exactly WIDTH*DIV+2 clocks between accepting edges. The last bit is 1 and all others are 0.

Source files
------------

// File: rtl/reg32_serializer_pkg.sv
// reg32_serializer_pkg
// Shared definitions for the word serializer and its bit-rate divider:
//   - state_t : FSM state encoding (IDLE / SHIFT / DONE)
//   - clog2   : ceiling log2, usable in constant expressions
//   - cnt_w   : counter width for a modulus n (never less than 1 bit)
package reg32_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int cnt_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/reg32_serializer_bit_tick_gen.sv
// reg32_serializer_bit_tick_gen
// Bit-period divider: while run is high it counts 0..DIV-1 and raises tick
// on the last clock of every period. The count is held at 0 whenever run is
// low, so each new frame starts on a full bit period. Shared with the
// matching deserializer.
// Ports:
//   clk   in  1  system clock, rising edge
//   clear in  1  asynchronous active-high reset
//   run   in  1  enable; count is forced to 0 while low
//   tick  out 1  high on the last clock of each DIV-clock period
module reg32_serializer_bit_tick_gen
  import reg32_serializer_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int            CW   = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // Terminal value always returns to 0, so the counter never wraps through
  // unused codes when DIV is not a power of two.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_cnt <= '0;
    end else if (!run || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // run comes from registered state in the parent, so tick is register-decoded.
  assign tick = run && (r_cnt == LAST);

endmodule

// File: rtl/reg32_serializer.sv
// reg32_serializer
// Captures a WIDTH-bit word on load (only while ready) and shifts it out
// MSB first, each bit held for DIV clocks. bit_tick marks the sampling clock
// of each bit and done pulses for one cycle after the last bit.
// All outputs are decoded from registers; nothing from load/D reaches an
// output combinationally.
// Ports:
//   clk      in  1      system clock, rising edge
//   clear    in  1      asynchronous active-high reset, aborts any transfer
//   load     in  1      capture request, honoured only while ready
//   D        in  WIDTH  word to transmit
//   ready    out 1      idle, a load is accepted this cycle
//   sdata    out 1      current serial bit, 0 when not shifting
//   svalid   out 1      a bit is being presented
//   bit_tick out 1      last clock of the current bit
//   done     out 1      one-cycle pulse after the final bit
module reg32_serializer
  import reg32_serializer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  output logic             ready,
  output logic             sdata,
  output logic             svalid,
  output logic             bit_tick,
  output logic             done
);

  localparam int            BW       = clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [BW-1:0]    r_bit_cnt;

  logic w_run;
  logic w_tick;

  assign w_run = (r_state == SHIFT);

  reg32_serializer_bit_tick_gen #(
    .DIV (DIV)
  ) u_bit_tick_gen (
    .clk   (clk),
    .clear (clear),
    .run   (w_run),
    .tick  (w_tick)
  );

  // Loads outside IDLE are simply not looked at, so a busy frame can never be
  // disturbed. bit_cnt holds at its terminal value in DONE and is re-zeroed
  // on the next accepted load rather than wrapping.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (load) begin
            r_shreg   <= D;
            r_bit_cnt <= '0;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_tick) begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            if (r_bit_cnt == LAST_BIT) begin
              r_state <= DONE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready    = (r_state == IDLE);
  assign svalid   = w_run;
  assign sdata    = w_run & r_shreg[WIDTH-1];
  assign bit_tick = w_tick;
  assign done     = (r_state == DONE);

endmodule

// File: tb/tb_reg32_serializer.sv
`timescale 1ns/1ps
module tb_reg32_serializer;

  localparam int WA = 32;
  localparam int DA = 4;
  localparam int FA = WA * DA;
  localparam int WB = 8;
  localparam int DB = 1;
  localparam int FB = WB * DB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: WIDTH=32, DIV=4
  logic          clear_a, load_a;
  logic [WA-1:0] d_a;
  logic          ready_a, sdata_a, svalid_a, tick_a, done_a;
  // instance B: WIDTH=8, DIV=1
  logic          clear_b, load_b;
  logic [WB-1:0] d_b;
  logic          ready_b, sdata_b, svalid_b, tick_b, done_b;

  reg32_serializer #(.WIDTH(WA), .DIV(DA)) dut_a (
    .clk(clk), .clear(clear_a), .load(load_a), .D(d_a),
    .ready(ready_a), .sdata(sdata_a), .svalid(svalid_a),
    .bit_tick(tick_a), .done(done_a)
  );

  reg32_serializer #(.WIDTH(WB), .DIV(DB)) dut_b (
    .clk(clk), .clear(clear_b), .load(load_b), .D(d_b),
    .ready(ready_b), .sdata(sdata_b), .svalid(svalid_b),
    .bit_tick(tick_b), .done(done_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: k = clocks since the accepting edge (0 = idle).
  // k=1..W*D : bit (k-1)/D presented, tick on the last clock of each bit
  // k=W*D+1  : done
  // Packed as {ready, sdata, svalid, bit_tick, done}.
  function automatic logic [4:0] exp_out(input int k, input logic [31:0] w,
                                         input int wd, input int dv);
    logic [4:0] e;
    e = 5'b0;
    if (k == 0) begin
      e[4] = 1'b1;
    end else if (k <= wd * dv) begin
      e[2] = 1'b1;
      e[3] = w[wd - 1 - (k - 1) / dv];
      e[1] = (((k - 1) % dv) == (dv - 1));
    end else begin
      e[0] = 1'b1;
    end
    return e;
  endfunction

  int          ka = 0, kb = 0;
  logic [31:0] wa = '0, wb = '0;

  always @(posedge clk or posedge clear_a) begin
    if (clear_a)          ka = 0;
    else if (ka == 0)     begin if (load_a) begin wa = d_a; ka = 1; end end
    else if (ka == FA + 1) ka = 0;
    else                  ka = ka + 1;
  end

  always @(posedge clk or posedge clear_b) begin
    if (clear_b)          kb = 0;
    else if (kb == 0)     begin if (load_b) begin wb = {24'd0, d_b}; kb = 1; end end
    else if (kb == FB + 1) kb = 0;
    else                  kb = kb + 1;
  end

  // Per-cycle output check plus a serial receiver reassembling each frame.
  logic [WA-1:0] rx_a = '0, last_rx_a = '0;
  logic [WB-1:0] rx_b = '0, last_rx_b = '0;
  int   rx_a_n = 0, sv_a_n = 0, rx_b_n = 0;
  logic sv_a_prev = 1'b0;
  int   rise_prev = 0, rise_last = 0;

  always @(negedge clk) begin
    chk("outs_a", {27'd0, ready_a, sdata_a, svalid_a, tick_a, done_a}, {27'd0, exp_out(ka, wa, WA, DA)});
    chk("outs_b", {27'd0, ready_b, sdata_b, svalid_b, tick_b, done_b}, {27'd0, exp_out(kb, wb, WB, DB)});
    if (clear_a) begin
      rx_a = '0; rx_a_n = 0; sv_a_n = 0;
    end else begin
      if (svalid_a && tick_a) begin rx_a = {rx_a[WA-2:0], sdata_a}; rx_a_n++; end
      if (svalid_a) sv_a_n++;
      if (svalid_a && !sv_a_prev) begin rise_prev = rise_last; rise_last = cyc; end
      if (done_a) begin
        chk("rx_bits_a", rx_a_n, WA);
        chk("sv_len_a", sv_a_n, FA);
        last_rx_a = rx_a;
        rx_a = '0; rx_a_n = 0; sv_a_n = 0;
      end
    end
    sv_a_prev = svalid_a;
    if (clear_b) begin
      rx_b = '0; rx_b_n = 0;
    end else begin
      if (svalid_b && tick_b) begin rx_b = {rx_b[WB-2:0], sdata_b}; rx_b_n++; end
      if (done_b) begin
        chk("rx_bits_b", rx_b_n, WB);
        last_rx_b = rx_b;
        rx_b = '0; rx_b_n = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_done_a(input int limit);
    int c;
    c = 0;
    while (!done_a && c < limit) begin step(1); c++; end
    if (!done_a) chk("timeout_done_a", 32'd0, 32'd1);
  endtask

  task automatic wait_done_b(input int limit);
    int c;
    c = 0;
    while (!done_b && c < limit) begin step(1); c++; end
    if (!done_b) chk("timeout_done_b", 32'd0, 32'd1);
  endtask

  task automatic send_a(input logic [WA-1:0] w);
    load_a = 1'b1; d_a = w;
    step(1);
    load_a = 1'b0; d_a = $urandom;
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit abort;
    int ab_at;
    clear_a = 1'b0; clear_b = 1'b0; load_a = 1'b0; load_b = 1'b0; d_a = '0; d_b = '0;
    #1;
    clear_a = 1'b1; clear_b = 1'b1;
    step(2);
    chk("rst_ready",  ready_a, 1);
    chk("rst_svalid", svalid_a, 0);
    chk("rst_done",   done_a, 0);
    clear_a = 1'b0; clear_b = 1'b0;
    step(3);

    // asynchronous clear mid-cycle with a pending load of all ones
    load_a = 1'b1; d_a = 32'hFFFF_FFFF;
    #1 clear_a = 1'b1;
    #1;
    chk("aclr_ready", ready_a, 1);
    chk("aclr_sdata", sdata_a, 0);
    chk("aclr_svalid", svalid_a, 0);
    step(3);
    chk("clr_hold_ready", ready_a, 1);
    load_a = 1'b0; clear_a = 1'b0;
    step(2);

    // basic frame, with loads issued at bit 10 and during DONE
    send_a(32'hA5A5_0F0F);
    chk("busy_ready", ready_a, 0);
    step(4 * 10 - 1);
    load_a = 1'b1; d_a = 32'h1234_5678;
    step(1);
    load_a = 1'b0;
    wait_done_a(FA + 10);
    load_a = 1'b1; d_a = 32'h1234_5678;
    step(1);
    load_a = 1'b0;
    chk("ready_after_done", ready_a, 1);
    chk("frame_word", last_rx_a, 32'hA5A5_0F0F);
    step(5);
    chk("no_extra_frame", svalid_a, 0);

    // DIV=1 on the 8-bit instance
    load_b = 1'b1; d_b = 8'h81;
    step(1);
    load_b = 1'b0;
    wait_done_b(FB + 10);
    step(1);
    chk("div1_word", {24'd0, last_rx_b}, 32'h81);

    // abort during bit 20, then a clean frame
    send_a(32'hDEAD_BEEF);
    step(4 * 20);
    clear_a = 1'b1;
    #1;
    chk("abort_svalid", svalid_a, 0);
    chk("abort_sdata",  sdata_a, 0);
    chk("abort_tick",   tick_a, 0);
    chk("abort_done",   done_a, 0);
    step(2);
    clear_a = 1'b0;
    step(3);
    send_a(32'h0000_FFFF);
    wait_done_a(FA + 10);
    step(1);
    chk("after_abort_word", last_rx_a, 32'h0000_FFFF);

    // back-to-back: reload in the first ready cycle after done
    send_a(32'h0000_0001);
    step(4);
    chk("btb_spacing", rise_last - rise_prev, FA + 2);
    wait_done_a(FA + 10);
    step(1);
    chk("btb_word", last_rx_a, 32'h0000_0001);

    // randomized frames with busy loads, D churn and random aborts
    for (int f = 0; f < 25; f++) begin
      abort = ($urandom_range(5) == 0);
      ab_at = $urandom_range(FA, 1);
      send_a($urandom);
      for (int c = 0; c < FA + 1; c++) begin
        load_a = ($urandom_range(3) == 0);
        d_a = $urandom;
        if (abort && c == ab_at) begin
          clear_a = 1'b1;
          step(2);
          clear_a = 1'b0;
          break;
        end
        step(1);
      end
      load_a = 1'b0;
      step(1 + $urandom_range(2));
      if (!abort) chk("rand_word_a", last_rx_a, wa);
    end

    // randomized control on the DIV=1 instance
    for (int c = 0; c < 300; c++) begin
      load_b  = ($urandom_range(2) == 0);
      d_b     = 8'($urandom);
      clear_b = ($urandom_range(39) == 0);
      step(1);
    end
    clear_b = 1'b0; load_b = 1'b0;
    step(FB + 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
